// File: rtl/mw_timer_pkg.sv
// rtl/mw_timer_pkg.sv - shared encodings and digit limits for the microwave timer sequencer
package mw_timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } mw_state_e;

    // The seconds-tens counter is mod 6, so keypad entries above 5 load as 5.
    function automatic logic [DIGIT_W-1:0] clamp_tens(input logic [DIGIT_W-1:0] v);
        return (v > SEC_TENS_MAX) ? SEC_TENS_MAX : v;
    endfunction

endpackage

// File: rtl/mw_tick_gen.sv
// rtl/mw_tick_gen.sv - timer-second prescaler with run/hold/clear and a one-cycle tick
module mw_tick_gen #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rstn,
    input  logic run_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Neither run_i low (hold) nor clr_i may produce a tick.
    assign tick_o = run_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/mw_timer_ctrl.sv
// rtl/mw_timer_ctrl.sv - microwave countdown sequencer: keypad entry, counter load, per-second borrow enables
// Optional MW_TIMER_AUTOBEEP_EN: DONE returns to IDLE by itself after BEEP_TICKS timer seconds.
module mw_timer_ctrl
    import mw_timer_pkg::*;
#(
    parameter int TICK_DIV   = 100,
    parameter int BEEP_TICKS = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               door_closed,
    input  logic               zero_su,
    input  logic               zero_st,
    input  logic               zero_min,
    output logic [DIGIT_W-1:0] ld_su,
    output logic [DIGIT_W-1:0] ld_st,
    output logic [DIGIT_W-1:0] ld_min,
    output logic               loadn,
    output logic               en_su,
    output logic               en_st,
    output logic               en_min,
    output logic               mag_on,
    output logic               done,
    output logic [2:0]         state
);

`ifdef MW_TIMER_AUTOBEEP_EN
    localparam bit AUTOBEEP = 1'b1;
`else
    localparam bit AUTOBEEP = 1'b0;
`endif

    localparam int BW = $clog2(BEEP_TICKS + 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

    mw_state_e          state_q;
    logic [DIGIT_W-1:0] su_q, st_q, min_q;
    logic [BW-1:0]      beep_q;

    logic tick, tick_run, tick_clr;
    logic all_zero, leave_run, entry_nz, digit_ok, go_load;

    assign all_zero  = zero_su & zero_st & zero_min;
    assign leave_run = clear | ~door_closed | stop;
    assign entry_nz  = |{su_q, st_q, min_q};
    assign digit_ok  = key_valid && (key_digit <= DIGIT_MAX);
    assign go_load   = start & door_closed & ~stop & entry_nz;

    // Prescaler holds in PAUSE so a resumed second keeps its elapsed fraction.
    always_comb begin
        tick_run = 1'b0;
        tick_clr = 1'b0;
        case (state_q)
            ST_RUN: begin
                tick_run = ~leave_run & ~all_zero;
                tick_clr = ~leave_run & all_zero;
            end
            ST_DONE:  tick_run = AUTOBEEP & ~clear;
            ST_PAUSE: tick_run = 1'b0;
            default:  tick_clr = 1'b1;
        endcase
    end

    mw_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .run_i  (tick_run),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            su_q    <= '0;
            st_q    <= '0;
            min_q   <= '0;
            beep_q  <= '0;
            ld_su   <= '0;
            ld_st   <= '0;
            ld_min  <= '0;
            loadn   <= 1'b1;
            en_su   <= 1'b0;
            en_st   <= 1'b0;
            en_min  <= 1'b0;
            mag_on  <= 1'b0;
            done    <= 1'b0;
        end else begin
            loadn  <= 1'b1;
            en_su  <= 1'b0;
            en_st  <= 1'b0;
            en_min <= 1'b0;
            mag_on <= 1'b0;
            done   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        {min_q, st_q, su_q}    <= '0;
                        {ld_min, ld_st, ld_su} <= '0;
                    end else if (go_load) begin
                        state_q <= ST_LOAD;
                        loadn   <= 1'b0;
                    end else if (digit_ok) begin
                        min_q  <= st_q;
                        st_q   <= su_q;
                        su_q   <= key_digit;
                        ld_min <= st_q;
                        ld_st  <= clamp_tens(su_q);
                        ld_su  <= key_digit;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_RUN;
                    mag_on  <= 1'b1;
                end
                ST_RUN: begin
                    if (clear) begin
                        state_q                <= ST_IDLE;
                        loadn                  <= 1'b0;
                        {min_q, st_q, su_q}    <= '0;
                        {ld_min, ld_st, ld_su} <= '0;
                    end else if (~door_closed | stop) begin
                        state_q <= ST_PAUSE;
                    end else if (all_zero) begin
                        state_q <= ST_DONE;
                        done    <= 1'b1;
                        beep_q  <= '0;
                    end else begin
                        mag_on <= 1'b1;
                        en_su  <= tick;
                        en_st  <= tick & zero_su;
                        en_min <= tick & zero_su & zero_st;
                    end
                end
                ST_PAUSE: begin
                    if (clear) begin
                        state_q                <= ST_IDLE;
                        loadn                  <= 1'b0;
                        {min_q, st_q, su_q}    <= '0;
                        {ld_min, ld_st, ld_su} <= '0;
                    end else if (door_closed & ~stop & start) begin
                        state_q <= ST_RUN;
                        mag_on  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (clear) begin
                        state_q                <= ST_IDLE;
                        {min_q, st_q, su_q}    <= '0;
                        {ld_min, ld_st, ld_su} <= '0;
                    end else begin
                        done <= 1'b1;
                        if (AUTOBEEP && tick) begin
                            if (beep_q == BEEP_LAST) begin
                                state_q <= ST_IDLE;
                                done    <= 1'b0;
                            end else begin
                                beep_q <= beep_q + BW'(1);
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: doc/mw_timer_ctrl.md
Name: mw_timer_ctrl

Overview:
- Sequencer for the microwave countdown timer.
- Collects keypad digits and loads three cascaded down-counters: seconds-units mod 10, seconds-tens mod 6, minutes mod 10.
- Generates the per-second decrement enables with borrow cascading, and drives magnetron-on and done.
- Sits between keypad/door logic and the digit counter instances.

Parameters:
- TICK_DIV, 100, clk cycles per timer second (internal prescaler); minimum 2.
- BEEP_TICKS, 3, seconds `done` stays high before auto-return to IDLE (used only with feature macro).

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, reset; synchronous, active-low.
- key_valid, input, 1, one-cycle keypad strobe.
- key_digit, input, 4, keypad value; values >9 ignored.
- start, input, 1, start/resume pulse.
- stop, input, 1, pause pulse.
- clear, input, 1, cancel/clear pulse.
- door_closed, input, 1, door interlock; 1 = closed.
- zero_su, input, 1, seconds-units counter at 0.
- zero_st, input, 1, seconds-tens counter at 0.
- zero_min, input, 1, minutes counter at 0.
- ld_su, output, 4, load data for seconds-units counter.
- ld_st, output, 4, load data for seconds-tens counter.
- ld_min, output, 4, load data for minutes counter.
- loadn, output, 1, active-low load strobe to all counters.
- en_su, output, 1, decrement enable for seconds-units counter.
- en_st, output, 1, decrement enable for seconds-tens counter.
- en_min, output, 1, decrement enable for minutes counter.
- mag_on, output, 1, magnetron drive.
- done, output, 1, cook-complete indicator.
- state, output, 3, FSM state for display/debug.

Behaviour:
- Reset (rstn low at posedge): state=IDLE; entry regs 0; ld_* = 0; loadn=1; en_*=0; mag_on=0; done=0; prescaler=0.
- States: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.
- IDLE, digit entry: key_valid with key_digit ≤9 shifts the entry regs: min←st, st←su, su←key_digit. Digits >9 are dropped.
- ld_* mirror the entry regs registered. ld_st is clamped to 5 when the entry value is >5.
- IDLE→LOAD: start & door_closed & entry≠0. With start and entry=0, stay in IDLE.
- LOAD: loadn=0 for exactly one cycle; prescaler cleared; next state RUN.
- RUN: mag_on=1. Prescaler increments each cycle; tick = prescaler==TICK_DIV-1, after which the prescaler wraps to 0.
  - en_su = tick.
  - en_st = tick & zero_su.
  - en_min = tick & zero_su & zero_st.
  - If zero_su & zero_st & zero_min: go to DONE, with no enables that cycle.
- RUN→PAUSE: stop, or door_closed=0. mag_on drops on the same edge. Prescaler holds its value.
- PAUSE→RUN: start & door_closed. The prescaler resumes from its held value.
- Clear from RUN or PAUSE: pulse loadn=0 with ld_*=0 for one cycle, clear the entry regs, go to IDLE.
- DONE: done=1, mag_on=0. clear→IDLE. start is ignored.
- Priority on simultaneous inputs: clear > door open > stop > start. key_valid is ignored outside IDLE.
- Invariant: loadn=0 and any en_*=1 are never asserted in the same cycle. The counters give enable priority over load.
- Every output is registered, with 1-cycle latency from the input event.
- Reset mid-operation returns to IDLE on the next edge. The counters are reset separately by the shared rstn.

Optional Feature:
- MW_TIMER_AUTOBEEP_EN defined: DONE counts BEEP_TICKS seconds using the prescaler, then clears done and returns to IDLE on its own. clear still exits early.
- Not defined: DONE holds until clear.

Decomposition:
- Package mw_timer_pkg: state encodings, DIGIT_W=4, SEC_TENS_MAX=5, DIGIT_MAX=9.
- Sub-module mw_tick_gen: prescaler with run/hold/clear inputs and a one-cycle tick output, parameterised by TICK_DIV.

Test Plan:
1. Keys 1,3,0 then start, door closed → loadn low 1 cycle with ld_min=1, ld_st=3, ld_su=0; RUN; mag_on=1.
2. Counters at 1:00 in RUN, tick → en_su=en_st=en_min=1 in that cycle. Next state with counters at 0 → DONE, done=1, mag_on=0.
3. Door opens mid-RUN at prescaler=40 → PAUSE next edge, mag_on=0. Close door + start → first tick after TICK_DIV-40 cycles.
4. clear and start same cycle in PAUSE → IDLE; loadn pulse with all ld_*=0; no RUN.
5. Keys 9,9 then start, TICK_DIV=4 → ld_st clamped to 5. Entry 0 + start → stays IDLE, loadn stays 1.
6. With MW_TIMER_AUTOBEEP_EN, BEEP_TICKS=3, TICK_DIV=4 → done high 12 cycles, then IDLE. Without the macro → done holds until clear.
